pipe_idex_reg: RTL
==================

PIPE_IDEX_REG -- requirements
Module: pipe_idex_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and bubble event counters.
REQ-002 SHALL have port clock, in, 1, the single rising-edge clock.
REQ-003 SHALL have port resetn, in, 1, asynchronous active-low reset.
REQ-004 SHALL have port stall, in, 1, hold the current EX contents (load-use hazard).
REQ-005 SHALL have port flush, in, 1, insert a bubble (taken branch or jump).
REQ-006 SHALL have port d_valid, in, 1, the ID stage holds a real instruction.
REQ-007 SHALL have ports d_qa and d_qb, in, 32 each, register-file rs and rt read values.
REQ-008 SHALL have port d_imm, in, 32, the already-extended immediate.
REQ-009 SHALL have port d_sa, in, 5, the shift amount.
REQ-010 SHALL have port d_rn, in, 5, the destination register number.
REQ-011 SHALL have port d_pc4, in, 32, PC+4 of the ID instruction.
REQ-012 SHALL have port d_aluc, in, 4, ALU opcode (ADD/SUB/AND/OR/XOR/LUI/SLL/SRL/SRA encoding).
REQ-013 SHALL have ports d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem and d_jal, in, 1 each, control bits.
REQ-014 SHALL have ports d_fwda and d_fwdb, in, 2 each, forward select: 00 register, 01 ex_r, 10 mem_r, 11 mem_mo.
REQ-015 SHALL have ports ex_r, mem_r and mem_mo, in, 32 each, the forwarding sources.
REQ-016 SHALL have ports e_a and e_b, out, 32 each, registered ALU operands.
REQ-017 SHALL have port e_aluc, out, 4, registered ALU opcode.
REQ-018 SHALL have port e_sdata, out, 32, registered store data (forwarded rt).
REQ-019 SHALL have port e_rn, out, 5, registered destination register number.
REQ-020 SHALL have port e_pc8, out, 32, registered PC+8.
REQ-021 SHALL have ports e_valid, e_wreg, e_m2reg, e_wmem and e_jal, out, 1 each, registered control bits.
REQ-022 SHALL have ports stall_cnt and bubble_cnt, out, CNT_W each, event counters.

Function
REQ-023 SHALL select fa from d_qa, ex_r, mem_r or mem_mo per d_fwda, and fb from d_qb likewise per d_fwdb, combinationally in ID.
REQ-024 SHALL compute next a = d_shift ? zero-extended d_sa : fa, so SLL/SRL/SRA receive the shift amount on a.
REQ-025 SHALL compute next b = d_aluimm ? d_imm : fb, and next sdata = fb regardless of d_aluimm.
REQ-026 SHALL compute next pc8 = d_pc4 + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-027 SHALL, on each rising clock with flush=1, load a bubble: e_valid, e_wreg, e_m2reg, e_wmem and e_jal = 0; all data outputs and e_aluc = 0.
REQ-028 SHALL, with flush=0 and stall=1, hold every registered output unchanged.
REQ-029 SHALL, with flush=0 and stall=0, load all next values, latency one cycle from ID inputs to e_* outputs.
REQ-030 SHALL give flush priority over stall when both are 1.
REQ-031 SHALL, when loading with d_valid=0, load the bubble of REQ-027.
REQ-032 SHALL increment stall_cnt on each clock with stall=1 and flush=0.
REQ-033 SHALL increment bubble_cnt on each clock with flush=1, or with stall=0 and d_valid=0.
REQ-034 SHALL saturate both counters at all-ones, with no wrap.
REQ-035 SHALL use no combinational path from any input to any output.

Reset
REQ-036 SHALL, while resetn=0, immediately force all outputs, including both counters, to 0, independent of clock.
REQ-037 SHALL, when reset is asserted mid-stall or mid-flush, discard the held contents; after resetn rises, the first clock edge obeys REQ-027 to REQ-031.

Verification
REQ-038 Reset then load with d_qa=5, d_qb=7, fwd=00, aluc=ADD, d_valid=1 -> next edge e_a=5, e_b=7, e_valid=1.
REQ-039 d_fwda=01, ex_r=0x1234, d_fwdb=11, mem_mo=0xDEAD, aluimm=0 -> e_a=0x1234, e_b=0xDEAD, e_sdata=0xDEAD.
REQ-040 shift=1, sa=31, aluimm=1, imm=0xFFFF8000 -> e_a=0x1F, e_b=0xFFFF8000; d_pc4=0xFFFFFFFC -> e_pc8=0.
REQ-041 Hold stall=1 for 3 cycles with changing inputs -> outputs unchanged, stall_cnt=3; then stall=flush=1 -> bubble loaded, bubble_cnt=1, stall_cnt still 3.
REQ-042 Force stall_cnt to all-ones with CNT_W=4 (16 stall cycles) -> stays 0xF on further stalls.
REQ-043 Pulse resetn low between clock edges during a stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_idex_reg.sv
// ID/EX pipeline register: operand forwarding and immediate/shift-amount muxing in ID,
// registered EX contents with stall hold, flush/invalid bubbles, and saturating event counters.
module pipe_idex_reg #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             stall,
   input  logic             flush,
   input  logic             d_valid,
   input  logic [31:0]      d_qa,
   input  logic [31:0]      d_qb,
   input  logic [31:0]      d_imm,
   input  logic [4:0]       d_sa,
   input  logic [4:0]       d_rn,
   input  logic [31:0]      d_pc4,
   input  logic [3:0]       d_aluc,
   input  logic             d_aluimm,
   input  logic             d_shift,
   input  logic             d_wreg,
   input  logic             d_m2reg,
   input  logic             d_wmem,
   input  logic             d_jal,
   input  logic [1:0]       d_fwda,
   input  logic [1:0]       d_fwdb,
   input  logic [31:0]      ex_r,
   input  logic [31:0]      mem_r,
   input  logic [31:0]      mem_mo,
   output logic [31:0]      e_a,
   output logic [31:0]      e_b,
   output logic [3:0]       e_aluc,
   output logic [31:0]      e_sdata,
   output logic [4:0]       e_rn,
   output logic [31:0]      e_pc8,
   output logic             e_valid,
   output logic             e_wreg,
   output logic             e_m2reg,
   output logic             e_wmem,
   output logic             e_jal,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic [31:0] fa;
   logic [31:0] fb;
   logic        load_bubble;
   logic        count_stall;

   always_comb begin
      fa = d_qa;
      case (d_fwda)
         2'b01:   fa = ex_r;
         2'b10:   fa = mem_r;
         2'b11:   fa = mem_mo;
         default: fa = d_qa;
      endcase
   end

   always_comb begin
      fb = d_qb;
      case (d_fwdb)
         2'b01:   fb = ex_r;
         2'b10:   fb = mem_r;
         2'b11:   fb = mem_mo;
         default: fb = d_qb;
      endcase
   end

   // Flush wins over stall; an unstalled load of an empty ID slot is also a bubble.
   assign load_bubble = flush | (~stall & ~d_valid);
   assign count_stall = stall & ~flush;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         e_a     <= '0;
         e_b     <= '0;
         e_aluc  <= '0;
         e_sdata <= '0;
         e_rn    <= '0;
         e_pc8   <= '0;
         e_valid <= 1'b0;
         e_wreg  <= 1'b0;
         e_m2reg <= 1'b0;
         e_wmem  <= 1'b0;
         e_jal   <= 1'b0;
      end else if (load_bubble) begin
         e_a     <= '0;
         e_b     <= '0;
         e_aluc  <= '0;
         e_sdata <= '0;
         e_rn    <= '0;
         e_pc8   <= '0;
         e_valid <= 1'b0;
         e_wreg  <= 1'b0;
         e_m2reg <= 1'b0;
         e_wmem  <= 1'b0;
         e_jal   <= 1'b0;
      end else if (!stall) begin
         e_a     <= d_shift ? {27'd0, d_sa} : fa;
         e_b     <= d_aluimm ? d_imm : fb;
         e_aluc  <= d_aluc;
         e_sdata <= fb;
         e_rn    <= d_rn;
         e_pc8   <= d_pc4 + 32'd4;
         e_valid <= 1'b1;
         e_wreg  <= d_wreg;
         e_m2reg <= d_m2reg;
         e_wmem  <= d_wmem;
         e_jal   <= d_jal;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (count_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (load_bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule
